// File: rtl/accel_mem_xfer.sv
// accel_mem_xfer: accelerator-side requester on the shared CPU data memory port.
// Reads one 64-byte block per request. Writes a result block back as a burst
// of consecutive 32-bit words. It holds the port through a mem_req/mem_gnt pair.
// Optional build macro: ACCEL_MEM_BYTESWAP_EN. When it is defined, every 32-bit
// word is byte-reversed on the write path and at read capture.
module accel_mem_xfer #(
    parameter int WR_WORDS = 8,   // words per write burst, 1..16
    parameter int RD_LAT   = 1    // granted address edge -> read data sample edge
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_req,
    input  logic [15:0]             rd_addr,
    output logic                    rd_valid,
    output logic [511:0]            rd_block,
    input  logic                    wr_req,
    input  logic [15:0]             wr_addr,
    input  logic [32*WR_WORDS-1:0]  wr_block,
    output logic                    wr_done,
    output logic                    busy,
    output logic                    mem_req,
    input  logic                    mem_gnt,
    output logic [15:0]             mem_addr,
    output logic [31:0]             mem_wrt_data,
    output logic                    mem_wrt_en,
    input  logic [511:0]            mem_rd_data
);

    localparam int WB = 32 * WR_WORDS;

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, RD_DONE, WR_BURST, WR_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    addr_q;      // latched base address
    logic [WB-1:0]  blk_q;       // write data, shifted down one word per granted write
    logic [4:0]     k_q;         // word index within the burst
    logic [7:0]     lat_q;       // remaining read latency
    logic [511:0]   rd_block_q;
    logic [31:0]    wr_word;
    logic [15:0]    wr_off;

`ifdef ACCEL_MEM_BYTESWAP_EN
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [511:0] rd_fmt(input logic [511:0] d);
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = bswap32(d[32*i +: 32]);
        return r;
    endfunction

    assign wr_word = bswap32(blk_q[31:0]);
`else
    function automatic logic [511:0] rd_fmt(input logic [511:0] d);
        return d;
    endfunction

    assign wr_word = blk_q[31:0];
`endif

    // The byte offset 4k is added modulo 2^16, so a burst wraps the way the memory does.
    assign wr_off   = {9'd0, k_q, 2'b00};
    assign rd_block = rd_block_q;

    // State, latched request and burst/latency counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            blk_q      <= '0;
            k_q        <= '0;
            lat_q      <= '0;
            rd_block_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (rd_req) begin
                        addr_q <= rd_addr;
                    end else if (wr_req) begin
                        addr_q <= wr_addr;
                        blk_q  <= wr_block;
                        k_q    <= '0;
                    end
                end
                RD_REQ: begin
                    if (mem_gnt) lat_q <= 8'(RD_LAT - 1);
                end
                RD_WAIT: begin
                    if (lat_q == 8'd0) rd_block_q <= rd_fmt(mem_rd_data);
                    else               lat_q      <= lat_q - 8'd1;
                end
                WR_BURST: begin
                    if (mem_gnt) begin
                        k_q   <= k_q + 5'd1;
                        blk_q <= blk_q >> 32;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state and port outputs. Port lines are driven only in active states.
    always_comb begin
        state_d      = state_q;
        busy         = 1'b1;
        rd_valid     = 1'b0;
        wr_done      = 1'b0;
        mem_req      = 1'b0;
        mem_addr     = '0;
        mem_wrt_data = '0;
        mem_wrt_en   = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (rd_req)      state_d = RD_REQ;
                else if (wr_req) state_d = WR_BURST;
            end
            RD_REQ: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                if (mem_gnt) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // The address is held so the memory output stays stable. Grant loss is harmless here.
                mem_req  = 1'b1;
                mem_addr = addr_q;
                if (lat_q == 8'd0) state_d = RD_DONE;
            end
            RD_DONE: begin
                rd_valid = 1'b1;
                state_d  = IDLE;
            end
            WR_BURST: begin
                mem_req      = 1'b1;
                mem_addr     = addr_q + wr_off;
                mem_wrt_data = wr_word;
                // Gated by rst so a reset edge cannot commit one more word.
                mem_wrt_en   = mem_gnt & ~rst;
                if (mem_gnt && k_q == 5'(WR_WORDS - 1)) state_d = WR_DONE;
            end
            WR_DONE: begin
                wr_done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_accel_mem_xfer.sv
// Directed bench for accel_mem_xfer (default build, WR_WORDS=8, RD_LAT=1).
// It uses a byte-wide memory model with one cycle of registered read latency.
module tb_accel_mem_xfer;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_req;
    logic [15:0]   rd_addr;
    logic          rd_valid;
    logic [511:0]  rd_block;
    logic          wr_req;
    logic [15:0]   wr_addr;
    logic [255:0]  wr_block;
    logic          wr_done;
    logic          busy;
    logic          mem_req;
    logic          mem_gnt;
    logic [15:0]   mem_addr;
    logic [31:0]   mem_wrt_data;
    logic          mem_wrt_en;
    logic [511:0]  mem_rd_data;

    int checks = 0;
    int errors = 0;

    accel_mem_xfer #(.WR_WORDS(8), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_block(rd_block),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_block(wr_block), .wr_done(wr_done),
        .busy(busy), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
        .mem_wrt_data(mem_wrt_data), .mem_wrt_en(mem_wrt_en), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    // Memory model, write log and pulse counters.
    logic [7:0]  mem [65536];
    bit          loaded = 1'b0;
    logic [15:0] wlog_addr [$];
    logic [31:0] wlog_data [$];
    int          wlog_cyc  [$];
    int          cyc = 0;
    int          wr_done_cnt = 0;
    int          rd_valid_cnt = 0;
    int          bad_en = 0;

    always @(posedge clk) begin
        logic [511:0] rd;
        if (rst && !loaded) begin
            for (int i = 0; i < 65536; i++)
                mem[i] <= (i >= 16'h5000 && i < 16'h5080) ? 8'(i - 16'h5000) : 8'h00;
            loaded <= 1'b1;
        end
        rd = '0;
        for (int j = 0; j < 64; j++) rd[8*j +: 8] = mem[16'(mem_addr + j)];
        mem_rd_data <= rd;
        if (mem_wrt_en) begin
            for (int j = 0; j < 4; j++) mem[16'(mem_addr + j)] <= mem_wrt_data[8*j +: 8];
            wlog_addr.push_back(mem_addr);
            wlog_data.push_back(mem_wrt_data);
            wlog_cyc.push_back(cyc);
        end
        if (mem_wrt_en && !mem_gnt) bad_en++;
        if (wr_done)  wr_done_cnt++;
        if (rd_valid) rd_valid_cnt++;
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem32(input logic [15:0] a);
        return {mem[16'(a+3)], mem[16'(a+2)], mem[16'(a+1)], mem[a]};
    endfunction

    // Clears the single-cycle requests after the request edge. Counts negedges until the pulse.
    task automatic wait_pulse(input bit want_rd, output int n);
        n = 0;
        do begin
            @(negedge clk);
            rd_req = 1'b0;
            wr_req = 1'b0;
            n++;
        end while (!(want_rd ? rd_valid : wr_done) && n < 64);
    endtask

    initial begin
        int n, c, b0, wd0, rv0;
        logic [511:0] exp;

        rst = 1'b1; rd_req = 0; wr_req = 0; rd_addr = 0; wr_addr = 0; wr_block = 0; mem_gnt = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_busy",    busy, 0);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_addr",    mem_addr, 0);
        chk("reset_rdblk",   rd_block, 0);
        rst = 1'b0;
        @(negedge clk);

        // Read 64 bytes at 0x5000 with the grant held high.
        rd_addr = 16'h5000; rd_req = 1'b1;
        wait_pulse(1, n);
        chk("rd_latency", n, 3);
        for (int j = 0; j < 64; j++) exp[8*j +: 8] = 8'(j);
        chk("rd_block_full", rd_block, exp);
        chk("rd_byte0",  rd_block[7:0], 8'h00);
        chk("rd_byte63", rd_block[511:504], 8'h3F);
        @(negedge clk);
        chk("rd_valid_pulse", rd_valid, 0);

        // Write an 8-word burst at 0x9000 with the grant held high.
        wlog_addr.delete(); wlog_data.delete(); wlog_cyc.delete();
        wr_addr = 16'h9000;
        for (int k = 0; k < 8; k++) wr_block[32*k +: 32] = 32'h11111111 * (k + 1);
        wr_req = 1'b1;
        wait_pulse(0, n);
        chk("wr_latency", n, 9);
        chk("wr_count", wlog_addr.size(), 8);
        for (int k = 0; k < 8 && k < wlog_addr.size(); k++) begin
            chk("wr_addr", wlog_addr[k], 16'h9000 + 16'(4*k));
            chk("wr_data", wlog_data[k], 32'h11111111 * (k + 1));
            chk("wr_consec", wlog_cyc[k] - wlog_cyc[0], k);
        end
        chk("mem_901C", mem[16'h901C], 8'h88);
        @(negedge clk);
        chk("wr_done_pulse", wr_done, 0);

        // Toggle the grant 1,0,0,1 during the burst.
        wlog_addr.delete(); wlog_data.delete(); wlog_cyc.delete();
        b0 = bad_en; wd0 = wr_done_cnt;
        wr_addr = 16'h9100;
        for (int k = 0; k < 8; k++) wr_block[32*k +: 32] = 32'hA0000000 + k;
        wr_req = 1'b1;
        c = 0;
        while (c < 64) begin
            @(negedge clk);
            wr_req = 1'b0;
            if (wr_done) break;
            mem_gnt = (c % 4 == 0) || (c % 4 == 3);
            c++;
        end
        mem_gnt = 1'b1;
        chk("gt_done_cycle", c, 16);
        chk("gt_en_only_granted", bad_en - b0, 0);
        chk("gt_count", wlog_addr.size(), 8);
        for (int k = 0; k < 8 && k < wlog_addr.size(); k++) begin
            chk("gt_addr", wlog_addr[k], 16'h9100 + 16'(4*k));
            chk("gt_data", wlog_data[k], 32'hA0000000 + k);
        end
        @(negedge clk);
        chk("gt_done_once", wr_done_cnt - wd0, 1);

        // Simultaneous rd_req/wr_req, then wr_req during the read: only the read runs.
        wlog_addr.delete(); wlog_data.delete(); wlog_cyc.delete();
        wd0 = wr_done_cnt; rv0 = rd_valid_cnt;
        rd_addr = 16'h5004; wr_addr = 16'h9200; rd_req = 1'b1; wr_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            rd_req = 1'b0;
            n++;
            wr_req = (n <= 2);
        end while (!rd_valid && n < 64);
        wr_req = 1'b0;
        chk("both_rd_latency", n, 3);
        chk("both_byte0",  rd_block[7:0], 8'h04);
        chk("both_byte63", rd_block[511:504], 8'h43);
        repeat (4) @(negedge clk);
        chk("both_no_write", wlog_addr.size(), 0);
        chk("both_no_wr_done", wr_done_cnt - wd0, 0);
        chk("both_rd_once", rd_valid_cnt - rv0, 1);
        chk("both_idle", busy, 0);

        // Burst that wraps past 0xFFFF.
        wlog_addr.delete(); wlog_data.delete(); wlog_cyc.delete();
        wr_addr = 16'hFFF8;
        for (int k = 0; k < 8; k++) wr_block[32*k +: 32] = 32'hC0DE0000 + k;
        wr_req = 1'b1;
        wait_pulse(0, n);
        chk("wrap_latency", n, 9);
        chk("wrap_count", wlog_addr.size(), 8);
        for (int k = 0; k < 8 && k < wlog_addr.size(); k++)
            chk("wrap_addr", wlog_addr[k], 16'(16'hFFF8 + 4*k));
        if (wlog_addr.size() == 8) begin
            chk("wrap_addr2", wlog_addr[2], 16'h0000);
            chk("wrap_addr7", wlog_addr[7], 16'h0014);
        end
        chk("wrap_mem_FFFC", mem32(16'hFFFC), 32'hC0DE0001);
        chk("wrap_mem_0014", mem32(16'h0014), 32'hC0DE0007);
        @(negedge clk);

        // Reset asserted after the third granted write.
        wlog_addr.delete(); wlog_data.delete(); wlog_cyc.delete();
        wd0 = wr_done_cnt;
        wr_addr = 16'hA000;
        for (int k = 0; k < 8; k++) wr_block[32*k +: 32] = 32'hBEEF0000 + k;
        wr_req = 1'b1;
        @(negedge clk);
        wr_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pre_writes", wlog_addr.size(), 3);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy",     busy, 0);
        chk("rst_mem_req",  mem_req, 0);
        chk("rst_wrt_en",   mem_wrt_en, 0);
        chk("rst_addr",     mem_addr, 0);
        chk("rst_wdata",    mem_wrt_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wr_done",  wr_done, 0);
        chk("rst_rdblk",    rd_block, 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("rst_no_wr_done", wr_done_cnt - wd0, 0);
        chk("rst_write_total", wlog_addr.size(), 3);
        chk("rst_mem_w2", mem32(16'hA008), 32'hBEEF0002);
        chk("rst_mem_w3", mem32(16'hA00C), 32'h00000000);
        chk("rst_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
